vending_coin_feeder: RTL and testbench

Payment-side driver for the 3-unit vending controller. It owns the coin lines `i`/`j` and consumes the `x` (dispense) and `y` (change) responses. Loaded with a wallet of 2-unit and 1-unit coins and an item count, it inserts coins one per cycle, waits for each vend, and banks any returned change. It reports items bought, changes received, a short-funds stop and a protocol error. It sits between a test/host controller and the vending controller, as the bus-functional transmitter for that interface.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/vending_coin_feeder.sv | 167 ++++++++++++++++
 tb/tb_vending_coin_feeder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions between the vending controller and its coin feeder:
// coin line encodings, item price, coin values and the feeder state encoding.
package vending_pkg;

  localparam int PRICE = 3;

  localparam logic [1:0] COIN_BIG   = 2'b10;
  localparam logic [1:0] COIN_SMALL = 2'b01;
  localparam logic [1:0] COIN_NONE  = 2'b00;

  localparam logic [2:0] VAL_BIG   = 3'd2;
  localparam logic [2:0] VAL_SMALL = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FEED  = 3'd2,
    ST_VEND  = 3'd3,
    ST_FIN   = 3'd4
  } feeder_state_e;

  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    logic [2:0] val;
    case (coin)
      COIN_BIG:   val = VAL_BIG;
      COIN_SMALL: val = VAL_SMALL;
      default:    val = 3'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_coin_feeder.sv
// Bus-functional payment driver for the vending controller: feeds coins from a
// loaded wallet one per cycle, checks each vend/change response, banks change.
module vending_coin_feeder #(
  parameter int PRICE = vending_pkg::PRICE,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n_items,
  input  logic [CW-1:0] big_in,
  input  logic [CW-1:0] small_in,
  input  logic          x,
  input  logic          y,
  output logic          i,
  output logic          j,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] items,
  output logic [CW-1:0] changes,
  output logic          short,
  output logic          err
);
  import vending_pkg::*;

  localparam logic [2:0]    PRICE3 = 3'(PRICE);
  localparam logic [CW+1:0] PRICEW = (CW+2)'(PRICE);

  feeder_state_e state_q, state_d;
  logic [1:0]    coin_q, coin_d;
  logic [2:0]    credit_q, credit_d;
  logic [CW-1:0] big_q, big_d, small_q, small_d, nreq_q, nreq_d;
  logic [CW-1:0] items_q, items_d, changes_q, changes_d;
  logic          short_q, short_d, err_q, err_d, busy_q, done_q;

  logic [2:0]    credit_base_s;
  logic [1:0]    sel_s;
  logic [CW+1:0] wallet_val_s;

  // Prefer the coin that closes the gap without overpaying; fall back to the other.
  function automatic logic [1:0] pick_coin(input logic [2:0] need,
                                           input logic [CW-1:0] nb,
                                           input logic [CW-1:0] ns);
    logic [1:0] c;
    if (need >= 3'd2) begin
      if (nb != '0)      c = COIN_BIG;
      else if (ns != '0) c = COIN_SMALL;
      else               c = COIN_NONE;
    end else begin
      if (ns != '0)      c = COIN_SMALL;
      else if (nb != '0) c = COIN_BIG;
      else               c = COIN_NONE;
    end
    return c;
  endfunction

  assign wallet_val_s = {1'b0, big_q, 1'b0} + {2'b00, small_q};

  always_comb begin
    state_d       = state_q;
    coin_d        = COIN_NONE;
    credit_d      = credit_q;
    big_d         = big_q;
    small_d       = small_q;
    nreq_d        = nreq_q;
    items_d       = items_q;
    changes_d     = changes_q;
    short_d       = short_q;
    err_d         = err_q;
    // The coin registered at this edge is shown next cycle, so pick it one cycle ahead.
    if (state_q == ST_CHECK) credit_base_s = 3'd0;
    else                     credit_base_s = credit_q;
    sel_s = pick_coin(PRICE3 - credit_base_s, big_q, small_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          big_d     = big_in;
          small_d   = small_in;
          nreq_d    = n_items;
          items_d   = '0;
          changes_d = '0;
          short_d   = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK, ST_FEED: begin
        if (state_q == ST_CHECK && items_q == nreq_q) begin
          state_d = ST_FIN;
        end else if (state_q == ST_CHECK && wallet_val_s < PRICEW) begin
          short_d = 1'b1;
          state_d = ST_FIN;
        end else if (state_q == ST_FEED && credit_q >= PRICE3) begin
          state_d = ST_VEND;
        end else begin
          coin_d   = sel_s;
          credit_d = credit_base_s + coin_value(sel_s);
          if (sel_s == COIN_BIG && big_q != '0)          big_d   = big_q - CW'(1);
          else if (sel_s == COIN_SMALL && small_q != '0) small_d = small_q - CW'(1);
          else                                           big_d   = big_q;
          state_d = ST_FEED;
        end
      end
      ST_VEND: begin
        if (x && (y == (credit_q == PRICE3 + 3'd1))) begin
          items_d = items_q + CW'(1);
          if (y) begin
            changes_d = changes_q + CW'(1);
            if (small_q == '1) small_d = small_q;
            else               small_d = small_q + CW'(1);
          end else begin
            changes_d = changes_q;
          end
          state_d = ST_CHECK;
        end else begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      coin_q    <= COIN_NONE;
      credit_q  <= 3'd0;
      big_q     <= '0;
      small_q   <= '0;
      nreq_q    <= '0;
      items_q   <= '0;
      changes_q <= '0;
      short_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      coin_q    <= coin_d;
      credit_q  <= credit_d;
      big_q     <= big_d;
      small_q   <= small_d;
      nreq_q    <= nreq_d;
      items_q   <= items_d;
      changes_q <= changes_d;
      short_q   <= short_d;
      err_q     <= err_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FIN);
    end
  end

  assign i       = coin_q[1];
  assign j       = coin_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign items   = items_q;
  assign changes = changes_q;
  assign short   = short_q;
  assign err     = err_q;

endmodule

// File: tb/tb_vending_coin_feeder.sv
// Bench for vending_coin_feeder: a behavioural vending controller answers the
// coins, and an order-level timeline model predicts every output cycle by cycle.
module tb_vending_coin_feeder;

  logic       clk, rst, start, x, y;
  logic [3:0] n_items, big_in, small_in;
  logic       i, j, busy, done, short, err;
  logic [3:0] items, changes;

  vending_coin_feeder #(.PRICE(3), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_items(n_items),
    .big_in(big_in), .small_in(small_in), .x(x), .y(y),
    .i(i), .j(j), .busy(busy), .done(done), .items(items),
    .changes(changes), .short(short), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] coin;
    logic       busy;
    logic       done;
    logic [3:0] items;
    logic [3:0] changes;
    logic       shrt;
    logic       err;
  } exp_t;

  exp_t tl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cyc;
  bit   saw_i;

  // Behavioural vending controller: sums coins, answers vend (+change) the cycle after reaching the price.
  int acc = 0;
  bit pend = 0, pend_y = 0, kill_x = 0;
  always @(negedge clk) begin
    if (rst) begin
      acc = 0; pend = 0; x = 1'b0; y = 1'b0;
    end else begin
      x = 1'($urandom); y = 1'($urandom);
      if (pend) begin
        x = !kill_x; y = pend_y; kill_x = 0; pend = 0;
      end
      if ({i, j} == 2'b10) acc += 2;
      else if ({i, j} == 2'b01) acc += 1;
      if (acc >= 3) begin pend = 1; pend_y = (acc == 4); acc = 0; end
    end
  end

  function automatic exp_t mk(input logic [1:0] c, input bit b, input bit d,
                              input int it, input int ch, input bit sh, input bit er);
    exp_t e;
    e.coin = c; e.busy = b; e.done = d; e.items = 4'(it); e.changes = 4'(ch);
    e.shrt = sh; e.err = er;
    return e;
  endfunction

  // Order-level model: lists what each cycle from cycle 1 to the done cycle must show.
  task automatic build(input int b, input int s, input int n, input bit kill);
    int it = 0, ch = 0, cr;
    bit sh = 0, er = 0;
    tl.delete();
    for (int guard = 0; guard < 40; guard++) begin
      tl.push_back(mk(2'b00, 1, 0, it, ch, sh, er));
      if (it == n) break;
      if (2 * b + s < 3) begin sh = 1; break; end
      cr = 0;
      while (cr < 3) begin
        if ((3 - cr >= 2 && b > 0) || (3 - cr == 1 && s == 0)) begin
          b--; cr += 2; tl.push_back(mk(2'b10, 1, 0, it, ch, sh, er));
        end else begin
          s--; cr += 1; tl.push_back(mk(2'b01, 1, 0, it, ch, sh, er));
        end
      end
      tl.push_back(mk(2'b00, 1, 0, it, ch, sh, er));
      if (kill && it == 0) begin er = 1; break; end
      it++;
      if (cr == 4) begin ch++; s = (s == 15) ? 15 : s + 1; end
    end
    tl.push_back(mk(2'b00, 1, 1, it, ch, sh, er));
  endtask

  task automatic check(input string nm, input int cyc, input exp_t e);
    exp_t g;
    g = mk({i, j}, busy, done, int'(items), int'(changes), short, err);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got coin=%b busy=%b done=%b items=%0d changes=%0d short=%b err=%b, want coin=%b busy=%b done=%b items=%0d changes=%0d short=%b err=%b",
               nm, cyc, g.coin, g.busy, g.done, g.items, g.changes, g.shrt, g.err,
               e.coin, e.busy, e.done, e.items, e.changes, e.shrt, e.err);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Runs one order with noisy inputs while busy; expects to be called with the DUT idle.
  task automatic run_order(input int b, input int s, input int n, input bit kill);
    exp_t last;
    build(b, s, n, kill);
    @(negedge clk);
    big_in = 4'(b); small_in = 4'(s); n_items = 4'(n); start = 1'b1; kill_x = kill;
    done_cyc = -1; saw_i = 0;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      start = 1'($urandom); n_items = 4'($urandom); big_in = 4'($urandom); small_in = 4'($urandom);
      check("order", k + 1, tl[k]);
      if (done && done_cyc < 0) done_cyc = k + 1;
      if (i) saw_i = 1;
    end
    @(negedge clk);
    start = 1'b0;
    last = tl[tl.size() - 1];
    check("idle_after", tl.size() + 1, mk(2'b00, 0, 0, int'(last.items), int'(last.changes), last.shrt, last.err));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_items = 4'd0; big_in = 4'd0; small_in = 4'd0;
    repeat (3) @(negedge clk);
    check("reset", 0, mk(2'b00, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    check("idle", 0, mk(2'b00, 0, 0, 0, 0, 0, 0));

    run_order(1, 1, 1, 0);
    check_int("t1_done_cycle", done_cyc, 6);
    check_int("t1_items", int'(items), 1);
    check_int("t1_changes", int'(changes), 0);

    run_order(2, 0, 1, 0);
    check_int("t2_changes", int'(changes), 1);
    check_int("t2_items", int'(items), 1);

    run_order(2, 1, 2, 0);
    check_int("t3_short", int'(short), 1);
    check_int("t3_items", int'(items), 1);

    run_order(0, 6, 2, 0);
    check_int("t4_items", int'(items), 2);
    check_int("t4_i_seen", int'(saw_i), 0);

    run_order(2, 2, 3, 1);
    check_int("t5_err", int'(err), 1);
    check_int("t5_items", int'(items), 0);
    run_order(1, 2, 1, 0);
    check_int("t5_err_cleared", int'(err), 0);

    run_order(0, 0, 0, 0);
    check_int("t6_zero_items_done", done_cyc, 2);

    // Reset during the second coin of an order.
    @(negedge clk);
    big_in = 4'd1; small_in = 4'd1; n_items = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rst_coin1", 2, mk(2'b10, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_coin2", 3, mk(2'b01, 1, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_order", 4, mk(2'b00, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_done", 5 + k, mk(2'b00, 0, 0, 0, 0, 0, 0));
    end
    run_order(1, 1, 1, 0);
    check_int("rst_restart_items", int'(items), 1);

    for (int t = 0; t < 40; t++) begin
      run_order(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
